// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core control path: opcodes, ALU codes,
// register indices, FSM states, instruction classes and the control word.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0111;
  localparam logic [3:0] OP_SWAP = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1010;
  localparam logic [3:0] OP_LI   = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;

  // Register indices 2..6 are general purpose; 7 is the branch register.
  localparam logic [2:0] REG_ZERO   = 3'd0;
  localparam logic [2:0] REG_IMM    = 3'd1;

  localparam logic [1:0] SET_NONE   = 2'b00;
  localparam logic [1:0] SET_IMM_R2 = 2'b10;
  localparam logic [1:0] SET_BRANCH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALTED
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LW,
    CLS_SW,
    CLS_SWAP,
    CLS_BEQ,
    CLS_JMP,
    CLS_LI,
    CLS_HALT
  } inst_class_t;

  typedef struct packed {
    logic       instReq;
    logic       memReq;
    logic       memWe;
    logic [2:0] aluOp;
    logic       wbSel;
    logic [1:0] readReg1;
    logic [2:0] readReg2;
    logic [2:0] writeReg;
    logic [1:0] setCtrl;
    logic       writeCtrl;
    logic       swapCtrl;
    logic       carryOut;
    logic       pcInc;
    logic       pcLoad;
    logic       halted;
    logic       fault;
  } ctrl_out_t;

endpackage

// File: rtl/inst_decoder.sv
// Combinational opcode decode: instruction class, ALU function, write-back
// register and the register-file read_val1 override.
module inst_decoder
  import cpu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [2:0]  i_r2,
  output inst_class_t o_class,
  output logic [2:0]  o_aluOp,
  output logic [2:0]  o_writeReg,
  output logic [1:0]  o_setCtrl
);

  always_comb begin
    o_class    = CLS_NOP;
    o_aluOp    = ALU_ADD;
    o_writeReg = i_r2;
    o_setCtrl  = SET_NONE;
    unique case (i_op)
      OP_ADD:  begin o_class = CLS_ALU; o_aluOp = ALU_ADD; end
      OP_SUB:  begin o_class = CLS_ALU; o_aluOp = ALU_SUB; end
      OP_AND:  begin o_class = CLS_ALU; o_aluOp = ALU_AND; end
      OP_OR:   begin o_class = CLS_ALU; o_aluOp = ALU_OR;  end
      OP_SLL:  begin o_class = CLS_ALU; o_aluOp = ALU_SLL; end
      OP_SRL:  begin o_class = CLS_ALU; o_aluOp = ALU_SRL; end
      OP_LW:   o_class = CLS_LW;
      OP_SW:   o_class = CLS_SW;
      OP_SWAP: o_class = CLS_SWAP;
      // Branch compare runs imm against r2 through a subtract.
      OP_BEQ:  begin o_class = CLS_BEQ; o_aluOp = ALU_SUB; o_setCtrl = SET_IMM_R2; end
      OP_JMP:  begin o_class = CLS_JMP; o_setCtrl = SET_BRANCH; end
      OP_LI:   begin o_class = CLS_LI; o_writeReg = REG_IMM; end
      OP_HALT: o_class = CLS_HALT;
      default: o_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: fetch/decode/exec/mem/wb sequencing with fully
// registered register-file, PC, ALU and data-memory controls.
module control_fsm
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] inst,
  input  logic       inst_valid,
  output logic       inst_req,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic [2:0] alu_op,
  output logic       wb_sel,
  output logic [1:0] read_reg1,
  output logic [2:0] read_reg2,
  output logic [2:0] write_reg,
  output logic [1:0] set_ctrl,
  output logic       write_ctrl,
  output logic       swap_ctrl,
  output logic       carry_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       halted,
  output logic       fault
);

  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [8:0]  r_inst;
  logic [8:0]  w_nextInst;
  logic [7:0]  r_waitCnt;
  logic [7:0]  w_nextCnt;
  logic        w_timeout;
  ctrl_out_t   r_out;
  ctrl_out_t   w_nextOut;

  inst_class_t w_class;
  logic [2:0]  w_decAluOp;
  logic [2:0]  w_decWriteReg;
  logic [1:0]  w_decSetCtrl;

  // Decode always looks at the instruction the next cycle will hold, so the
  // registered controls line up with the state they belong to.
  inst_decoder u_decoder (
    .i_op       (w_nextInst[8:5]),
    .i_r2       (w_nextInst[2:0]),
    .o_class    (w_class),
    .o_aluOp    (w_decAluOp),
    .o_writeReg (w_decWriteReg),
    .o_setCtrl  (w_decSetCtrl)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_inst    <= '0;
      r_waitCnt <= '0;
      r_out     <= '0;
    end else begin
      r_state   <= w_nextState;
      r_inst    <= w_nextInst;
      r_waitCnt <= w_nextCnt;
      r_out     <= w_nextOut;
    end
  end

  // The wait counter only survives while stalling in FETCH or MEM, so any
  // entry into either state starts it from zero.
  always_comb begin
    w_nextState = r_state;
    w_nextInst  = r_inst;
    w_nextCnt   = '0;
    w_timeout   = 1'b0;
    unique case (r_state)
      ST_IDLE: if (start) w_nextState = ST_FETCH;
      ST_FETCH: begin
        if (inst_valid) begin
          w_nextState = ST_DECODE;
          w_nextInst  = inst;
        end else if (r_waitCnt == LP_LAST_WAIT) begin
          w_nextState = ST_HALTED;
          w_timeout   = 1'b1;
        end else begin
          w_nextCnt = r_waitCnt + 8'd1;
        end
      end
      ST_DECODE: begin
        if (w_class == CLS_NOP)       w_nextState = ST_FETCH;
        else if (w_class == CLS_HALT) w_nextState = ST_HALTED;
        else                          w_nextState = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_class == CLS_ALU || w_class == CLS_LI)     w_nextState = ST_WB;
        else if (w_class == CLS_LW || w_class == CLS_SW) w_nextState = ST_MEM;
        else                                             w_nextState = ST_FETCH;
      end
      ST_MEM: begin
        if (mem_ready) begin
          w_nextState = (w_class == CLS_LW) ? ST_WB : ST_FETCH;
        end else if (r_waitCnt == LP_LAST_WAIT) begin
          w_nextState = ST_HALTED;
          w_timeout   = 1'b1;
        end else begin
          w_nextCnt = r_waitCnt + 8'd1;
        end
      end
      ST_WB:     w_nextState = ST_FETCH;
      ST_HALTED: w_nextState = ST_HALTED;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Output word for the next cycle, derived from the next state. A taken BEQ
  // needs alu_zero from its EXEC cycle, so its pc_load lands one cycle later.
  always_comb begin
    w_nextOut         = '0;
    w_nextOut.instReq = (w_nextState == ST_FETCH);
    w_nextOut.pcInc   = (r_state == ST_FETCH) && inst_valid;
    if (w_nextState inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
      w_nextOut.readReg1 = w_nextInst[4:3];
      w_nextOut.readReg2 = w_nextInst[2:0];
      w_nextOut.writeReg = w_decWriteReg;
    end else begin
      w_nextOut.writeReg = REG_ZERO;
    end
    if (w_nextState inside {ST_EXEC, ST_MEM, ST_WB}) begin
      w_nextOut.aluOp = w_decAluOp;
    end
    if (w_nextState == ST_EXEC) begin
      w_nextOut.setCtrl  = w_decSetCtrl;
      w_nextOut.swapCtrl = (w_class == CLS_SWAP);
      w_nextOut.pcLoad   = (w_class == CLS_JMP);
    end
    if (r_state == ST_EXEC && w_class == CLS_BEQ && alu_zero) begin
      w_nextOut.pcLoad = 1'b1;
    end
    if (w_nextState == ST_MEM) begin
      w_nextOut.memReq = 1'b1;
      w_nextOut.memWe  = (w_class == CLS_SW);
    end
    if (w_nextState == ST_WB) begin
      w_nextOut.writeCtrl = 1'b1;
      w_nextOut.wbSel     = (w_class == CLS_LW) || (w_class == CLS_LI);
      w_nextOut.carryOut  = (w_class == CLS_ALU) && (w_nextInst[8:5] == OP_ADD) && alu_carry;
    end
    if (w_nextState == ST_HALTED) begin
      w_nextOut.halted = 1'b1;
      w_nextOut.fault  = r_out.fault | w_timeout;
    end
  end

  assign inst_req   = r_out.instReq;
  assign mem_req    = r_out.memReq;
  assign mem_we     = r_out.memWe;
  assign alu_op     = r_out.aluOp;
  assign wb_sel     = r_out.wbSel;
  assign read_reg1  = r_out.readReg1;
  assign read_reg2  = r_out.readReg2;
  assign write_reg  = r_out.writeReg;
  assign set_ctrl   = r_out.setCtrl;
  assign write_ctrl = r_out.writeCtrl;
  assign swap_ctrl  = r_out.swapCtrl;
  assign carry_out  = r_out.carryOut;
  assign pc_inc     = r_out.pcInc;
  assign pc_load    = r_out.pcLoad;
  assign halted     = r_out.halted;
  assign fault      = r_out.fault;

endmodule
